// File: rtl/ahb_subordinate.sv
// AHB subordinate backed by a word-addressed scratch RAM, with a per-transfer
// wait-state count and the two-cycle ERROR response for illegal accesses.

package ahb_manager_pack;
    typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11} t_htrans;
    typedef enum logic [2:0] {BYTE, HALF, WORD, DWORD, LINE4, LINE8, LINE16, LINE32} t_hsize;
    typedef enum logic [2:0] {SINGLE, INCR, WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16} t_hburst;
    typedef enum logic [1:0] {OKAY = 2'b00, ERROR = 2'b01, RETRY = 2'b10, SPLIT = 2'b11} t_hresp;
endpackage

module ahb_subordinate
    import ahb_manager_pack::*;
#(
    parameter int DATA_WDT = 32,
    parameter int DEPTH    = 1024,
    parameter int WAIT_WDT = 4
) (
    input  logic                i_hclk,
    input  logic                i_hreset,
    input  logic                i_hsel,
    input  logic [31:0]         i_haddr,
    input  t_htrans             i_htrans,
    input  logic                i_hwrite,
    input  t_hsize              i_hsize,
    input  t_hburst             i_hburst,
    input  logic [DATA_WDT-1:0] i_hwdata,
    input  logic                i_hready,
    output logic                o_hready,
    output t_hresp              o_hresp,
    output logic [DATA_WDT-1:0] o_hrdata,
    input  logic [WAIT_WDT-1:0] i_wait_states
);

    localparam int          IDX_WDT    = $clog2(DEPTH);
    localparam int          LANES      = DATA_WDT / 8;
    localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);

    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2} t_state;

    t_state                state;
    t_state                next_state;
    logic [WAIT_WDT-1:0]   wait_cnt;
    logic [IDX_WDT+1:0]    addr_q;
    logic                  write_q;
    t_hsize                size_q;
    logic [DATA_WDT-1:0]   mem [DEPTH];

    logic                  accept;
    logic                  can_accept;
    logic                  take;
    logic                  illegal;
    logic [LANES-1:0]      byte_en;
    logic [IDX_WDT-1:0]    word_idx;
    logic                  unused_burst;

    // Every beat is decoded on its own, so the burst type carries no meaning here.
    assign unused_burst = ^i_hburst;

    assign accept     = i_hsel & i_hready & ((i_htrans == NONSEQ) | (i_htrans == SEQ));
    assign can_accept = (state == ST_IDLE) | (state == ST_DATA) | (state == ST_ERR2);
    assign take       = accept & can_accept;
    assign word_idx   = addr_q[IDX_WDT+1:2];

    always_comb begin
        illegal = 1'b0;
        if (i_haddr >= ADDR_LIMIT)
            illegal = 1'b1;
        if (i_hsize > WORD)
            illegal = 1'b1;
        if ((i_hsize == HALF) && i_haddr[0])
            illegal = 1'b1;
        if ((i_hsize == WORD) && (i_haddr[1:0] != 2'b00))
            illegal = 1'b1;
    end

    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            size_q   <= BYTE;
        end else begin
            state <= next_state;
            if (take) begin
                addr_q   <= i_haddr[IDX_WDT+1:0];
                write_q  <= i_hwrite;
                size_q   <= i_hsize;
                wait_cnt <= illegal ? '0 : i_wait_states;
            end else if ((state == ST_WAIT) && (wait_cnt != '0)) begin
                wait_cnt <= wait_cnt - WAIT_WDT'(1);
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (take) begin
                    if (illegal)
                        next_state = ST_ERR1;
                    else if (i_wait_states != '0)
                        next_state = ST_WAIT;
                    else
                        next_state = ST_DATA;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            // A count at or below one means the last wait cycle is now.
            ST_WAIT: if (wait_cnt <= WAIT_WDT'(1)) next_state = ST_DATA;
            ST_ERR1: next_state = ST_ERR2;
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        o_hready = 1'b1;
        o_hresp  = OKAY;
        o_hrdata = '0;
        case (state)
            ST_WAIT: o_hready = 1'b0;
            ST_DATA: if (!write_q) o_hrdata = mem[word_idx];
            ST_ERR1: begin
                o_hready = 1'b0;
                o_hresp  = ERROR;
            end
            ST_ERR2: o_hresp = ERROR;
            default: ;
        endcase
    end

    always_comb begin
        byte_en = '1;
        case (size_q)
            BYTE:    byte_en = LANES'(1) << addr_q[1:0];
            HALF:    byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
            default: byte_en = '1;
        endcase
    end

    // Write data arrives during the data phase, so the commit happens at its closing edge.
    always_ff @(posedge i_hclk) begin
        if (!i_hreset && (state == ST_DATA) && write_q) begin
            for (int b = 0; b < LANES; b++) begin
                if (byte_en[b])
                    mem[word_idx][8*b +: 8] <= i_hwdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ahb_subordinate.sv
// Directed bench for ahb_subordinate: single transfers, wait states, byte lanes,
// error responses, idle/busy handling, back-to-back access and reset mid-transfer.

module tb_ahb_subordinate;
    import ahb_manager_pack::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        hsel;
    logic [31:0] haddr;
    t_htrans     htrans;
    logic        hwrite;
    t_hsize      hsize;
    t_hburst     hburst;
    logic [31:0] hwdata;
    logic        hreadyIn;
    logic        hreadyOut;
    t_hresp      hresp;
    logic [31:0] hrdata;
    logic [3:0]  waitStates;

    int checkCount = 0;
    int failCount  = 0;

    logic [31:0] rdata;
    int          lowCycles;
    int          phaseCycles;
    t_hresp      firstResp;
    t_hresp      lastResp;

    always #5 clk = ~clk;

    // Single subordinate on the bus, so global HREADY is its own ready-out.
    assign hreadyIn = hreadyOut;

    ahb_subordinate #(.DATA_WDT(32), .DEPTH(1024), .WAIT_WDT(4)) dut (
        .i_hclk        (clk),
        .i_hreset      (reset),
        .i_hsel        (hsel),
        .i_haddr       (haddr),
        .i_htrans      (htrans),
        .i_hwrite      (hwrite),
        .i_hsize       (hsize),
        .i_hburst      (hburst),
        .i_hwdata      (hwdata),
        .i_hready      (hreadyIn),
        .o_hready      (hreadyOut),
        .o_hresp       (hresp),
        .o_hrdata      (hrdata),
        .i_wait_states (waitStates)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Issues one transfer from an idle bus and follows its data phase to completion.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input t_hsize size,
                                 input logic [31:0] wdata, input logic [3:0] waits,
                                 output logic [31:0] rd, output int lowCnt, output int phaseCnt,
                                 output t_hresp respFirst, output t_hresp respLast);
        hsel       = 1'b1;
        htrans     = NONSEQ;
        haddr      = addr;
        hwrite     = wr;
        hsize      = size;
        waitStates = waits;
        @(posedge clk); #1;
        hsel       = 1'b0;
        htrans     = IDLE;
        hwdata     = wdata;
        waitStates = 4'd0;
        lowCnt     = 0;
        phaseCnt   = 0;
        rd         = '0;
        respFirst  = OKAY;
        respLast   = OKAY;
        while (1) begin
            @(negedge clk);
            if (phaseCnt == 0)
                respFirst = hresp;
            phaseCnt++;
            respLast = hresp;
            rd       = hrdata;
            if (hreadyOut)
                break;
            lowCnt++;
            if (phaseCnt >= 40) begin
                checkOutput("timeout", 32'(phaseCnt), 32'd0);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic writeWord(input logic [31:0] addr, input logic [31:0] data);
        applyStimulus(1'b1, addr, WORD, data, 4'd0, rdata, lowCycles, phaseCycles, firstResp, lastResp);
    endtask

    task automatic readWord(input logic [31:0] addr);
        applyStimulus(1'b0, addr, WORD, 32'd0, 4'd0, rdata, lowCycles, phaseCycles, firstResp, lastResp);
    endtask

    initial begin
        reset      = 1'b1;
        hsel       = 1'b0;
        haddr      = '0;
        htrans     = IDLE;
        hwrite     = 1'b0;
        hsize      = WORD;
        hburst     = SINGLE;
        hwdata     = '0;
        waitStates = 4'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_hready", 32'(hreadyOut), 32'd1);
        checkOutput("reset_hresp", 32'(hresp), 32'(OKAY));
        checkOutput("reset_hrdata", hrdata, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        writeWord(32'h10, 32'hDEADBEEF);
        checkOutput("w10_low", 32'(lowCycles), 32'd0);
        checkOutput("w10_resp", 32'(lastResp), 32'(OKAY));
        readWord(32'h10);
        checkOutput("r10_data", rdata, 32'hDEADBEEF);
        checkOutput("r10_low", 32'(lowCycles), 32'd0);
        checkOutput("r10_resp", 32'(lastResp), 32'(OKAY));

        writeWord(32'h20, 32'h12345678);
        applyStimulus(1'b0, 32'h20, WORD, 32'd0, 4'd3, rdata, lowCycles, phaseCycles, firstResp, lastResp);
        checkOutput("wait3_low", 32'(lowCycles), 32'd3);
        checkOutput("wait3_phase", 32'(phaseCycles), 32'd4);
        checkOutput("wait3_data", rdata, 32'h12345678);
        checkOutput("wait3_resp", 32'(lastResp), 32'(OKAY));

        writeWord(32'h30, 32'h11223344);
        applyStimulus(1'b1, 32'h31, BYTE, 32'h5555AA55, 4'd0, rdata, lowCycles, phaseCycles, firstResp, lastResp);
        readWord(32'h30);
        checkOutput("byte31_merge", rdata, 32'h1122AA44);
        applyStimulus(1'b1, 32'h32, HALF, 32'hBEEF1234, 4'd0, rdata, lowCycles, phaseCycles, firstResp, lastResp);
        readWord(32'h30);
        checkOutput("half32_merge", rdata, 32'hBEEFAA44);

        writeWord(32'h0, 32'hCAFEF00D);
        applyStimulus(1'b0, 32'h1000, WORD, 32'd0, 4'd2, rdata, lowCycles, phaseCycles, firstResp, lastResp);
        checkOutput("oor_rd_first", 32'(firstResp), 32'(ERROR));
        checkOutput("oor_rd_low", 32'(lowCycles), 32'd1);
        checkOutput("oor_rd_last", 32'(lastResp), 32'(ERROR));
        checkOutput("oor_rd_data", rdata, 32'd0);
        applyStimulus(1'b1, 32'h1000, WORD, 32'h0BADBAD0, 4'd0, rdata, lowCycles, phaseCycles, firstResp, lastResp);
        checkOutput("oor_wr_last", 32'(lastResp), 32'(ERROR));
        readWord(32'h0);
        checkOutput("after_err_resp", 32'(lastResp), 32'(OKAY));
        checkOutput("oor_wr_nochange", rdata, 32'hCAFEF00D);

        applyStimulus(1'b1, 32'h3, HALF, 32'hFFFFFFFF, 4'd0, rdata, lowCycles, phaseCycles, firstResp, lastResp);
        checkOutput("half03_first", 32'(firstResp), 32'(ERROR));
        checkOutput("half03_phase", 32'(phaseCycles), 32'd2);
        readWord(32'h0);
        checkOutput("half03_nochange", rdata, 32'hCAFEF00D);
        applyStimulus(1'b0, 32'h12, WORD, 32'd0, 4'd0, rdata, lowCycles, phaseCycles, firstResp, lastResp);
        checkOutput("word12_misalign", 32'(firstResp), 32'(ERROR));
        applyStimulus(1'b0, 32'h10, DWORD, 32'd0, 4'd0, rdata, lowCycles, phaseCycles, firstResp, lastResp);
        checkOutput("dword_size", 32'(firstResp), 32'(ERROR));

        hsel   = 1'b1;
        haddr  = 32'h10;
        hwrite = 1'b1;
        hsize  = WORD;
        hwdata = 32'd0;
        htrans = IDLE;
        @(posedge clk); #1;
        htrans = BUSY;
        @(negedge clk);
        checkOutput("idle_hready", 32'(hreadyOut), 32'd1);
        checkOutput("idle_hresp", 32'(hresp), 32'(OKAY));
        @(posedge clk); #1;
        hsel   = 1'b0;
        htrans = IDLE;
        @(negedge clk);
        checkOutput("busy_hready", 32'(hreadyOut), 32'd1);
        checkOutput("busy_hresp", 32'(hresp), 32'(OKAY));
        @(posedge clk); #1;
        readWord(32'h10);
        checkOutput("idlebusy_nochange", rdata, 32'hDEADBEEF);

        hsel   = 1'b1;
        htrans = NONSEQ;
        haddr  = 32'h50;
        hwrite = 1'b1;
        hsize  = WORD;
        @(posedge clk); #1;
        hwdata = 32'h76543210;
        hwrite = 1'b0;
        @(posedge clk); #1;
        hsel   = 1'b0;
        htrans = IDLE;
        @(negedge clk);
        checkOutput("b2b_rd_data", hrdata, 32'h76543210);
        checkOutput("b2b_rd_hready", 32'(hreadyOut), 32'd1);
        @(posedge clk); #1;

        writeWord(32'h40, 32'h0BADF00D);
        hsel       = 1'b1;
        htrans     = NONSEQ;
        haddr      = 32'h40;
        hwrite     = 1'b1;
        hsize      = WORD;
        waitStates = 4'd5;
        @(posedge clk); #1;
        hsel       = 1'b0;
        htrans     = IDLE;
        waitStates = 4'd0;
        hwdata     = 32'h99999999;
        @(negedge clk);
        checkOutput("rst_wait_low", 32'(hreadyOut), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_hready", 32'(hreadyOut), 32'd1);
        checkOutput("rst_mid_hresp", 32'(hresp), 32'(OKAY));
        checkOutput("rst_mid_hrdata", hrdata, 32'd0);
        @(posedge clk); #1;
        readWord(32'h40);
        checkOutput("rst_mid_old", rdata, 32'h0BADF00D);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/ahb_subordinate.md
Name: ahb_subordinate

Overview:
- AHB subordinate (slave) that answers transfers issued by the team's AHB manager.
- Backed by an internal word-addressed memory, with a per-transfer programmable wait-state count.
- Issues the two-cycle ERROR response for illegal accesses. Never issues SPLIT or RETRY.
- Serves as the bench target for manager verification and as a scratch-RAM subordinate in SoC integration.
- Uses the t_htrans, t_hsize, t_hburst and t_hresp types from ahb_manager_pack.

Parameters:
- DATA_WDT, 32, bus data width. Only 32 is supported.
- DEPTH, 1024, memory depth in 32-bit words. Must be a power of two.
- WAIT_WDT, 4, width of the wait-state count.

Ports:
- i_hclk  in  1  clock.
- i_hreset  in  1  reset: synchronous, active-high.
- i_hsel  in  1  subordinate select.
- i_haddr  in  32  address.
- i_htrans  in  t_htrans  transfer type.
- i_hwrite  in  1  1 = write.
- i_hsize  in  t_hsize  transfer size.
- i_hburst  in  t_hburst  burst type. Ignored; every beat is decoded independently.
- i_hwdata  in  DATA_WDT  write data.
- i_hready  in  1  global HREADY (ready-in).
- o_hready  out  1  this subordinate's ready-out.
- o_hresp  out  t_hresp  response.
- o_hrdata  out  DATA_WDT  read data.
- i_wait_states  in  WAIT_WDT  wait states to insert for the transfer accepted this cycle.

Behaviour:
- Reset (i_hreset=1 at a clock edge): state=ST_IDLE, o_hready=1, o_hresp=OKAY, o_hrdata=0, wait counter=0. Memory contents are not reset.
- Accept condition: i_hsel & i_hready & (i_htrans==NONSEQ | i_htrans==SEQ).
  - On accept, register the data-phase controls: address, write, size, and the illegal flag.
  - When i_hready=1 and the accept condition is false (IDLE, BUSY, or i_hsel=0), next state=ST_IDLE.
  - When i_hready=0, no new transfer is captured and the state follows its own transitions.
- Illegal flag is set when any of these hold:
  - i_haddr >= DEPTH*4;
  - i_hsize > WORD;
  - misalignment: HALF with addr[0]!=0, or WORD with addr[1:0]!=0.
- State machine (one data phase in flight at a time):
  - ST_IDLE: o_hready=1, OKAY. On accept → ST_ERR1 if illegal; else ST_WAIT if i_wait_states>0 (counter loads i_wait_states); else ST_DATA.
  - ST_WAIT: o_hready=0, OKAY. Counter decrements each cycle; when counter==1 → ST_DATA.
  - ST_DATA: o_hready=1, OKAY, data phase completes this cycle. A new accept this cycle follows the same rules as in ST_IDLE; otherwise → ST_IDLE.
  - ST_ERR1: o_hready=0, o_hresp=ERROR → ST_ERR2.
  - ST_ERR2: o_hready=1, o_hresp=ERROR. Accept handling as in ST_DATA. A transfer the manager still presents here is accepted normally.
- Latency: N wait states give a data phase of N+1 cycles.
- Writes:
  - Commit to memory at the clock edge ending ST_DATA.
  - Little-endian byte lanes: BYTE writes lane addr[1:0]; HALF writes lanes addr[1]*2 and addr[1]*2+1; WORD writes all four.
  - Unwritten lanes are preserved.
  - Errored transfers never modify memory.
- Reads:
  - o_hrdata = mem[addr_q[log2(DEPTH)+1:2]] (full word, all lanes) while in ST_DATA with a read.
  - o_hrdata = 0 in all other states.
- Write-then-read to the same address back-to-back: the read returns the new data. The write commits before the read's data phase.
- Reset mid-transfer: the in-flight transfer is abandoned, no memory write occurs, and outputs return to their reset values next cycle.
- Wait counter never underflows. A load of 0 bypasses ST_WAIT.

Test Plan:
- Zero-wait WORD write 0xDEADBEEF to 0x10, then read 0x10 → o_hready stays 1; read data phase o_hrdata=0xDEADBEEF, OKAY.
- i_wait_states=3, read 0x20 → o_hready low exactly 3 cycles, then high with data; data phase is 4 cycles.
- BYTE write 0xAA to 0x31 over stored word 0x11223344 at 0x30 → read 0x30 returns 0x1122AA44.
- Read 0x1000 with DEPTH=1024 → o_hready=0/ERROR, then o_hready=1/ERROR; memory unchanged. The following legal transfer returns OKAY.
- HALF write to 0x03 → two-cycle ERROR, no memory change. IDLE and BUSY transfers → zero-wait OKAY, no state change.
- Assert i_hreset during ST_WAIT of a write → next cycle o_hready=1, OKAY, o_hrdata=0; a read of the target address returns the old value.
